// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns RX FIFO bytes into stopwatch/watch control pulses.
// Define CMD_ECHO_EN to echo every consumed byte back into the TX FIFO.
module uart_cmd_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] rx_pop_data,
    output logic       rx_pop,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_push_data,
    output logic       o_clear,
    output logic       o_runstop,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_sw,
    output logic       o_sw_setting,
    output logic       cmd_err
);

`ifdef CMD_ECHO_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ECHO   = 2'd2,
        WAIT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd3
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic       rx_pop_q, rx_pop_d;
    logic       clear_q, clear_d;
    logic       runstop_q, runstop_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic [1:0] sw_q, sw_d;
    logic       set_q, set_d;
    logic       err_q, err_d;
    logic [7:0] cmd_uc;

    // Fold lower-case letters onto upper case so the table is case-insensitive.
    assign cmd_uc = (cmd_q >= 8'h61 && cmd_q <= 8'h7A) ? cmd_q - 8'h20 : cmd_q;

`ifdef CMD_ECHO_EN
    logic       tx_push_q, tx_push_d;
    logic [7:0] tx_data_q, tx_data_d;

    assign tx_push      = tx_push_q;
    assign tx_push_data = tx_data_q;
`else
    logic unused_tx_full;

    assign unused_tx_full = tx_full;
    assign tx_push        = 1'b0;
    assign tx_push_data   = 8'h00;
`endif

    assign rx_pop       = rx_pop_q;
    assign o_clear      = clear_q;
    assign o_runstop    = runstop_q;
    assign o_up         = up_q;
    assign o_down       = down_q;
    assign o_sw         = sw_q;
    assign o_sw_setting = set_q;
    assign cmd_err      = err_q;

    // Next-state and registered-output logic; pulses default low each cycle.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rx_pop_d  = 1'b0;
        clear_d   = 1'b0;
        runstop_d = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        sw_d      = sw_q;
        set_d     = set_q;
        err_d     = 1'b0;
`ifdef CMD_ECHO_EN
        tx_push_d = 1'b0;
        tx_data_d = tx_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_empty) begin
                    cmd_d    = rx_pop_data;
                    rx_pop_d = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
`ifdef CMD_ECHO_EN
                state_d = ECHO;
`else
                state_d = WAIT;
`endif
                case (cmd_uc)
                    8'h43:        clear_d   = 1'b1;
                    8'h52:        runstop_d = 1'b1;
                    8'h55:        up_d      = 1'b1;
                    8'h44:        down_d    = 1'b1;
                    8'h4D:        sw_d      = sw_q + 2'd1;
                    8'h53:        set_d     = ~set_q;
                    8'h0D, 8'h0A: ;
                    default:      err_d     = 1'b1;
                endcase
            end
`ifdef CMD_ECHO_EN
            ECHO: begin
                if (!tx_full) begin
                    tx_push_d = 1'b1;
                    tx_data_d = cmd_q;
                    state_d   = WAIT;
                end
            end
`endif
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= 8'h00;
            rx_pop_q  <= 1'b0;
            clear_q   <= 1'b0;
            runstop_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            sw_q      <= 2'b00;
            set_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rx_pop_q  <= rx_pop_d;
            clear_q   <= clear_d;
            runstop_q <= runstop_d;
            up_q      <= up_d;
            down_q    <= down_d;
            sw_q      <= sw_d;
            set_q     <= set_d;
            err_q     <= err_d;
        end
    end

`ifdef CMD_ECHO_EN
    // Echo push strobe and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_push_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_push_q <= tx_push_d;
            tx_data_q <= tx_data_d;
        end
    end
`endif

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port rx_empty, input, 1 bit: RX FIFO empty flag.
REQ-004 SHALL have port rx_pop_data, input, 8 bits: RX FIFO head byte, valid while rx_empty=0.
REQ-005 SHALL have port rx_pop, output, 1 bit: one-cycle pop strobe to RX FIFO.
REQ-006 SHALL have port tx_full, input, 1 bit: TX FIFO full flag.
REQ-007 SHALL have port tx_push, output, 1 bit: one-cycle push strobe to TX FIFO.
REQ-008 SHALL have port tx_push_data, output, 8 bits: byte pushed to TX FIFO.
REQ-009 SHALL have ports o_clear, o_runstop, o_up, o_down, output, 1 bit each: one-cycle button-equivalent pulses to the stopwatch/watch block.
REQ-010 SHALL have port o_sw, output, 2 bits: mode select level for the stopwatch/watch block.
REQ-011 SHALL have port o_sw_setting, output, 1 bit: setting-mode level.
REQ-012 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on an unrecognised byte.

Function
REQ-013 SHALL implement FSM states IDLE, DECODE, ECHO, WAIT; all outputs registered.
REQ-014 IDLE: at an edge with rx_empty=0, SHALL latch rx_pop_data into cmd_reg, drive rx_pop=1 for the next cycle only, and go to DECODE; with rx_empty=1, SHALL stay in IDLE.
REQ-015 DECODE: at the next edge, SHALL drive rx_pop=0 and assert exactly one decoded pulse for one cycle; the command pulse is high in the cycle 2 edges after the IDLE sample edge.
REQ-016 Decode table, case-insensitive: 'C' -> o_clear, 'R' -> o_runstop, 'U' -> o_up, 'D' -> o_down.
REQ-017 Decode table, mode bytes: 'M' -> o_sw <= o_sw+1 modulo 4 (3 wraps to 0); 'S' -> o_sw_setting toggles; neither produces a pulse.
REQ-018 0x0D and 0x0A SHALL be consumed silently, with no pulse and no cmd_err.
REQ-019 Any other byte SHALL assert cmd_err for one cycle, with no other output change.
REQ-020 From DECODE, SHALL go to ECHO when echo is compiled in, else to WAIT.
REQ-021 ECHO: at an edge with tx_full=0, SHALL drive tx_push=1 for one cycle with tx_push_data=cmd_reg, then go to WAIT; while tx_full=1, SHALL hold in ECHO with tx_push=0 and drop no byte.
REQ-022 WAIT: SHALL clear all pulses and tx_push, then return to IDLE, giving the FIFO one cycle to update rx_empty after the pop.
REQ-023 Throughput SHALL be one byte per 3 cycles without echo and per 4 cycles with echo and tx_full=0.
REQ-024 rx_pop SHALL never be asserted while rx_empty=1, and at most once per decoded byte.

Reset
REQ-025 While reset=1 at an edge, SHALL set state=IDLE, cmd_reg=0, rx_pop=0, tx_push=0, tx_push_data=0, all pulses=0, cmd_err=0, o_sw=2'b00, o_sw_setting=0.
REQ-026 Reset in IDLE with a byte pending SHALL leave that byte in the FIFO (no pop issued); reset in DECODE/ECHO SHALL discard the popped byte with no pulse and no echo.

Configuration
REQ-027 Macro CMD_ECHO_EN defined: ECHO state present; every consumed byte, including CR/LF and invalid bytes, is pushed to TX.
REQ-028 Macro CMD_ECHO_EN undefined: ECHO state absent; tx_push and tx_push_data tied to 0; tx_full ignored.

Verification
REQ-029 Scenario: rx_pop_data=0x52 ('R') with rx_empty=0 at edge E0 -> rx_pop high cycle after E0, o_runstop high exactly cycle after E1, all other outputs 0.
REQ-030 Scenario: four 'm' bytes from reset -> o_sw sequence 01,10,11,00; no pulses.
REQ-031 Scenario: byte 0x5A ('Z') -> cmd_err single pulse; then 0x0D -> no cmd_err, rx_pop still pulses once.
REQ-032 Scenario: CMD_ECHO_EN with 'c' and tx_full=1 for 5 cycles -> o_clear pulses, tx_push stays 0, then tx_push=1 with tx_push_data=0x63 on the first edge after tx_full falls.
REQ-033 Scenario: reset asserted in DECODE after 'U' popped -> no o_up pulse, o_sw=00, next byte 'D' decodes normally.
REQ-034 Scenario: back-to-back 'U','D' with rx_empty held low -> exactly two rx_pop pulses, 3 cycles apart without echo.
